// File: rtl/alu_issue_seq.sv
// Issue sequencer between decoder and registered ALU: register file, valid/ready accept,
// ALU latency wait and writeback. Optional immediate operand: define ALU_ISSUE_SEQ_IMM_EN.
package alu_issue_seq_pkg;
    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;
    localparam logic [3:0] ALU_OP_AND = 4'h2;
    localparam logic [3:0] ALU_OP_OR  = 4'h3;
    localparam logic [3:0] ALU_OP_XOR = 4'h4;
    localparam logic [3:0] ALU_OP_SWP = 4'h5;
endpackage

module alu_issue_seq #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 16,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
`ifdef ALU_ISSUE_SEQ_IMM_EN
    input  logic              in_imm,
`endif
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              ld_en,
    input  logic [3:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    // WAIT lasts ALU_LAT-1 cycles: counter runs ALU_LAT-2 down to 0.
    localparam logic [3:0] CNT_INIT = (ALU_LAT > 1) ? 4'(ALU_LAT - 2) : 4'd0;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] rf [NREG];
    logic [3:0]        rd_q;
    logic [3:0]        cnt;
    logic [3:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] b_sel;
    logic              accept;

    assign in_ready = (state == S_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign wb_valid = (state == S_WB) && !reset;
    assign wb_rd    = wb_valid ? rd_q  : wb_rd_q;
    assign wb_data  = wb_valid ? alu_y : wb_data_q;
    assign dbg_data = rf[dbg_addr];

`ifdef ALU_ISSUE_SEQ_IMM_EN
    assign b_sel = in_imm ? {{(DATA_W-4){1'b0}}, in_rt} : rf[in_rt];
`else
    assign b_sel = rf[in_rt];
`endif

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (ALU_LAT == 1) ? S_WB : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_q      <= '0;
            cnt       <= '0;
            alu_ctrl  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            // NOTE: the register file is architecturally visible after reset, so it is cleared here; this costs a reset net per entry, unlike a plain RAM.
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_ctrl <= in_op;
                alu_a    <= rf[in_rs];
                alu_b    <= b_sel;
                rd_q     <= in_rd;
            end
            if (state == S_ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (ld_en) begin
                rf[ld_addr] <= ld_data;
            end
            // Later assignment takes precedence: writeback beats an external load to the same index.
            if (wb_valid) begin
                rf[rd_q]  <= alu_y;
                wb_rd_q   <= rd_q;
                wb_data_q <= alu_y;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: one ALU_LAT=1 instance and one ALU_LAT=3 instance,
// each fed by a behavioural pipelined ALU model.
module tb_alu_issue_seq;
    import alu_issue_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [3:0]  dbg_addr = '0;
`ifdef ALU_ISSUE_SEQ_IMM_EN
    logic        in_imm = 1'b0;
`endif

    logic        in_ready, wb_valid;
    logic [3:0]  alu_ctrl, wb_rd;
    logic [15:0] alu_a, alu_b, alu_y, wb_data, dbg_data;
    logic        in_ready3, wb_valid3;
    logic [3:0]  alu_ctrl3, wb_rd3;
    logic [15:0] alu_a3, alu_b3, alu_y3, wb_data3, dbg_data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.DATA_W(16), .NREG(16), .ALU_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
`ifdef ALU_ISSUE_SEQ_IMM_EN
        .in_imm(in_imm),
`endif
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu_issue_seq #(.DATA_W(16), .NREG(16), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
`ifdef ALU_ISSUE_SEQ_IMM_EN
        .in_imm(in_imm),
`endif
        .alu_ctrl(alu_ctrl3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_y(alu_y3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_valid(wb_valid3), .wb_rd(wb_rd3), .wb_data(wb_data3),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data3)
    );

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            ALU_OP_ADD: return a + b;
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_XOR: return a ^ b;
            ALU_OP_SWP: return {a[11:8], a[15:12], a[3:0], a[7:4]};
            default:    return 16'h0000;
        endcase
    endfunction

    // Registered ALU models: result appears ALU_LAT cycles after inputs are presented.
    logic [15:0] p1;
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(alu_ctrl, alu_a, alu_b);
        p3[0] <= alu_f(alu_ctrl3, alu_a3, alu_b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign alu_y  = p1;
    assign alu_y3 = p3[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_reg(input logic [3:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Issue on the LAT=1 instance; returns cycles from accept to wb_valid and the writeback.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [3:0] rt, output int lat, output logic [3:0] got_rd,
                            output logic [15:0] got_data);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!wb_valid && lat < 20) begin
            step();
            lat++;
        end
        got_rd = wb_rd;
        got_data = wb_data;
        step();
    endtask

    task automatic rf_all_zero(output int bad);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            if (dbg_data !== 16'h0 || dbg_data3 !== 16'h0) bad++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    initial begin
        vec_t        vecs[7];
        int          lat, bad, seen;
        logic [3:0]  grd;
        logic [15:0] gdata;

        vecs[0] = '{ALU_OP_ADD, 16'h0003, 16'h0005, 16'h0008};
        vecs[1] = '{ALU_OP_ADD, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[2] = '{ALU_OP_SUB, 16'h0005, 16'h0007, 16'hFFFE};
        vecs[3] = '{ALU_OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[4] = '{ALU_OP_OR,  16'h1200, 16'h0034, 16'h1234};
        vecs[5] = '{ALU_OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555};
        vecs[6] = '{4'hF,       16'h1111, 16'h2222, 16'h0000};

        // Reset state.
        step();
        check("ready_in_reset", 32'(in_ready), 0);
        reset = 1'b0;
        step();
        check("ready_after_reset", 32'(in_ready), 1);
        check("reset_wb_valid", 32'(wb_valid), 0);
        check("reset_outs", {alu_ctrl, alu_a, wb_rd, 8'(wb_data)}, 0);
        check("reset_alu_b", 32'(alu_b), 0);
        rf_all_zero(bad);
        check("reset_rf_zero", 32'(bad), 0);

        // Scenario 1 cycle by cycle: accept at N, writeback at N+2, visible at N+3.
        ld_reg(4'd1, 16'h0003);
        ld_reg(4'd2, 16'h0005);
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd3; in_rs = 4'd1; in_rt = 4'd2;
        dbg_addr = 4'd3;
        check("n_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("n1_ready", 32'(in_ready), 0);
        check("n1_wb_valid", 32'(wb_valid), 0);
        check("n1_alu_in", {alu_ctrl, 12'h0, alu_a}, {ALU_OP_ADD, 12'h0, 16'h0003});
        check("n1_alu_b", 32'(alu_b), 32'h5);
        step();
        check("n2_wb", {7'h0, wb_valid, wb_rd, wb_data}, {7'h0, 1'b1, 4'd3, 16'h0008});
        check("n2_dbg_old", 32'(dbg_data), 0);
        step();
        check("n3_wb_valid", 32'(wb_valid), 0);
        check("n3_ready", 32'(in_ready), 1);
        check("n3_dbg", 32'(dbg_data), 32'h8);
        check("n3_wb_hold", {wb_rd, wb_data}, {4'd3, 16'h0008});

        // Table of operations via r1, r2 -> r3.
        for (int i = 0; i < 7; i++) begin
            ld_reg(4'd1, vecs[i].a);
            ld_reg(4'd2, vecs[i].b);
            do_instr(vecs[i].op, 4'd3, 4'd1, 4'd2, lat, grd, gdata);
            check($sformatf("vec%0d_lat", i), 32'(lat), 2);
            check($sformatf("vec%0d_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].op));
            check($sformatf("vec%0d_wb", i), {grd, gdata}, {4'd3, vecs[i].y});
            dbg_addr = 4'd3;
            #1;
            check($sformatf("vec%0d_rf", i), 32'(dbg_data), 32'(vecs[i].y));
        end

        // Back-to-back with in_valid held high: accepts at N and N+3.
        ld_reg(4'd1, 16'h0100);
        ld_reg(4'd2, 16'h0023);
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd6; in_rs = 4'd1; in_rt = 4'd2;
        check("b2b_n_ready", 32'(in_ready), 1);
        step();
        in_op = ALU_OP_XOR; in_rd = 4'd7;
        check("b2b_n1_ready", 32'(in_ready), 0);
        step();
        check("b2b_n2_ready", 32'(in_ready), 0);
        check("b2b_n2_wb", {7'h0, wb_valid, wb_rd, wb_data}, {7'h0, 1'b1, 4'd6, 16'h0123});
        step();
        check("b2b_n3_ready", 32'(in_ready), 1);
        check("b2b_n3_ctrl_held", 32'(alu_ctrl), 32'(ALU_OP_ADD));
        step();
        in_valid = 1'b0;
        check("b2b_n4_ctrl", 32'(alu_ctrl), 32'(ALU_OP_XOR));
        step();
        check("b2b_n5_wb", {7'h0, wb_valid, wb_rd, wb_data}, {7'h0, 1'b1, 4'd7, 16'h0123});
        step();

        // Aliasing and SWP.
        ld_reg(4'd1, 16'h1234);
        do_instr(ALU_OP_SUB, 4'd1, 4'd1, 4'd1, lat, grd, gdata);
        dbg_addr = 4'd1;
        #1;
        check("alias_sub_r1", 32'(dbg_data), 0);
        ld_reg(4'd5, 16'hABCD);
        do_instr(ALU_OP_SWP, 4'd2, 4'd5, 4'd0, lat, grd, gdata);
        dbg_addr = 4'd2;
        #1;
        check("swp_r2", 32'(dbg_data), 32'hBADC);

        // Load in the accept cycle: operands take the old value, the load still lands.
        ld_reg(4'd1, 16'h0040);
        ld_reg(4'd2, 16'h0002);
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd3; in_rs = 4'd1; in_rt = 4'd2;
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 16'h0700;
        step();
        in_valid = 1'b0; ld_en = 1'b0;
        check("ld_accept_alu_a", 32'(alu_a), 32'h0040);
        step();
        check("ld_accept_wb", 32'(wb_data), 32'h0042);
        step();
        dbg_addr = 4'd1;
        #1;
        check("ld_accept_r1", 32'(dbg_data), 32'h0700);

        // Load collides with writeback: same index -> WB wins, other index -> both write.
        ld_reg(4'd1, 16'h0008);
        ld_reg(4'd2, 16'h0008);
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd4; in_rs = 4'd1; in_rt = 4'd2;
        step();
        in_valid = 1'b0;
        step();
        check("collide_wb_cycle", 32'(wb_valid), 1);
        ld_en = 1'b1; ld_addr = 4'd4; ld_data = 16'hFFFF;
        step();
        ld_en = 1'b0;
        dbg_addr = 4'd4;
        #1;
        check("collide_same_r4", 32'(dbg_data), 32'h0010);
        in_valid = 1'b1; in_op = ALU_OP_SUB; in_rd = 4'd4; in_rs = 4'd1; in_rt = 4'd2;
        step();
        in_valid = 1'b0;
        step();
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 16'h5A5A;
        step();
        ld_en = 1'b0;
        dbg_addr = 4'd5;
        #1;
        check("collide_diff_r5", 32'(dbg_data), 32'h5A5A);
        dbg_addr = 4'd4;
        #1;
        check("collide_diff_r4", 32'(dbg_data), 0);

        // Reset during ISSUE on the LAT=1 instance.
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd9; in_rs = 4'd1; in_rt = 4'd2;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        seen = int'(wb_valid);
        check("rst_issue_ready_low", 32'(in_ready), 0);
        reset = 1'b0;
        step();
        seen += int'(wb_valid);
        check("rst_issue_ready", 32'(in_ready), 1);
        step();
        seen += int'(wb_valid);
        check("rst_issue_no_wb", 32'(seen), 0);
        rf_all_zero(bad);
        check("rst_issue_rf_zero", 32'(bad), 0);
        check("rst_issue_alu_a", 32'(alu_a), 0);

        // LAT=3 instance: full transaction, writeback at N+4.
        do_reset();
        ld_reg(4'd1, 16'h0003);
        ld_reg(4'd2, 16'h0004);
        in_valid = 1'b1; in_op = ALU_OP_ADD; in_rd = 4'd3; in_rs = 4'd1; in_rt = 4'd2;
        check("l3_n_ready", 32'(in_ready3), 1);
        step();
        in_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 3; k++) begin
            seen += int'(wb_valid3) + int'(in_ready3);
            step();
        end
        check("l3_quiet_n1_n3", 32'(seen), 0);
        check("l3_n4_wb", {7'h0, wb_valid3, wb_rd3, wb_data3}, {7'h0, 1'b1, 4'd3, 16'h0007});
        step();
        check("l3_n5_ready", 32'(in_ready3), 1);
        dbg_addr = 4'd3;
        #1;
        check("l3_rf_r3", 32'(dbg_data3), 32'h7);

        // LAT=3 instance: reset while in WAIT.
        in_valid = 1'b1; in_op = ALU_OP_SUB; in_rd = 4'd8; in_rs = 4'd1; in_rt = 4'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        seen = int'(wb_valid3);
        reset = 1'b1;
        step();
        seen += int'(wb_valid3);
        reset = 1'b0;
        step();
        check("rst_wait_ready", 32'(in_ready3), 1);
        for (int k = 0; k < 4; k++) begin
            seen += int'(wb_valid3);
            step();
        end
        check("rst_wait_no_wb", 32'(seen), 0);
        rf_all_zero(bad);
        check("rst_wait_rf_zero", 32'(bad), 0);

`ifdef ALU_ISSUE_SEQ_IMM_EN
        do_reset();
        ld_reg(4'd1, 16'h0010);
        ld_reg(4'd15, 16'h0005);
        in_imm = 1'b1;
        do_instr(ALU_OP_ADD, 4'd4, 4'd1, 4'hF, lat, grd, gdata);
        check("imm_lat", 32'(lat), 2);
        check("imm_r4", 32'(gdata), 32'h001F);
        in_imm = 1'b0;
        do_instr(ALU_OP_ADD, 4'd4, 4'd1, 4'hF, lat, grd, gdata);
        check("reg_r4", 32'(gdata), 32'h0015);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
